// File: rtl/mesi_isc_snoop_seq_if.sv
// mesi_isc_snoop_seq_if
// Groups the broadcast-FIFO pop port and the per-port coherence bus of the
// snoop sequencer.
//
// Handshakes:
//   FIFO pop  - the head is valid whenever broad_fifo_empty_i is 0 (show-ahead
//               FIFO). broad_fifo_rd_o is asserted in a cycle that consumes the
//               head. The head is removed on that rising edge.
//   Coherence - cbus_cmd_array_o carries a registered 3-bit command per port
//               (port p at [3p+2:3p]). A port accepts its command by raising
//               cbus_ack_array_i[p] for one cycle while the command is non-NOP.
//               Acks on ports that are showing NOP are ignored.
//
// Modports: slave = sequencer side, master = FIFO / cache-port side.
interface mesi_isc_snoop_seq_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int BROAD_ID_WIDTH = 5
);
  logic                      broad_fifo_empty_i;
  logic [1:0]                broad_type_i;
  logic [1:0]                broad_cpu_id_i;
  logic [BROAD_ID_WIDTH-1:0] broad_id_i;
  logic [ADDR_WIDTH-1:0]     broad_addr_i;
  logic [3:0]                cpu_present_i;
  logic [3:0]                cbus_ack_array_i;
  logic                      broad_fifo_rd_o;
  logic [11:0]               cbus_cmd_array_o;
  logic [ADDR_WIDTH-1:0]     cbus_addr_o;
  logic [BROAD_ID_WIDTH-1:0] active_id_o;
  logic                      busy_o;
  logic                      err_o;
  logic                      timeout_o;

  modport slave (
    input  broad_fifo_empty_i, broad_type_i, broad_cpu_id_i, broad_id_i,
           broad_addr_i, cpu_present_i, cbus_ack_array_i,
    output broad_fifo_rd_o, cbus_cmd_array_o, cbus_addr_o, active_id_o,
           busy_o, err_o, timeout_o
  );

  modport master (
    output broad_fifo_empty_i, broad_type_i, broad_cpu_id_i, broad_id_i,
           broad_addr_i, cpu_present_i, cbus_ack_array_i,
    input  broad_fifo_rd_o, cbus_cmd_array_o, cbus_addr_o, active_id_o,
           busy_o, err_o, timeout_o
  );
endinterface

// File: rtl/mesi_isc_snoop_seq.sv
// mesi_isc_snoop_seq
// Serialises broadcast coherence requests: pops one request from the
// broadcast FIFO, snoops every other populated port, then enables the
// originating port. One transaction is in flight at a time; a watchdog aborts
// transactions that stall.
//
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   bus        - FIFO head / pop and per-port coherence command/ack (slave)
//   state_dbg  - current FSM state (0=IDLE, 1=SNOOP, 2=ENABLE)
module mesi_isc_snoop_seq #(
  parameter int ADDR_WIDTH     = 32,
  parameter int BROAD_ID_WIDTH = 5,
  parameter int TIMEOUT        = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  mesi_isc_snoop_seq_if.slave  bus,
  output logic [1:0]           state_dbg
);

  localparam logic [1:0] TYPE_WR      = 2'd1;
  localparam logic [1:0] TYPE_RD      = 2'd2;
  localparam logic [2:0] CMD_WR_SNOOP = 3'd1;
  localparam logic [2:0] CMD_RD_SNOOP = 3'd2;
  localparam logic [2:0] CMD_EN_WR    = 3'd3;
  localparam logic [2:0] CMD_EN_RD    = 3'd4;
  // Abort when the cycle being counted is the TIMEOUT-th in SNOOP/ENABLE.
  localparam logic [7:0] WD_LIMIT     = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SNOOP = 2'd1, ENABLE = 2'd2} state_t;

  state_t                    state_q, state_n;
  logic [3:0]                pend_q, pend_n;
  logic [11:0]               cmd_q, cmd_n;
  logic [7:0]                wd_q, wd_n, wd_inc;
  logic                      err_q, err_n;
  logic                      tmo_q, tmo_n;
  logic                      is_wr_q;
  logic [1:0]                origin_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [BROAD_ID_WIDTH-1:0] id_q;
  logic                      pop, head_valid, latch;
  logic [3:0]                head_pend;

  function automatic logic [11:0] snoop_cmds(input logic [3:0] pend, input logic wr);
    logic [11:0] c;
    c = '0;
    for (int p = 0; p < 4; p++)
      if (pend[p]) c[3*p +: 3] = wr ? CMD_WR_SNOOP : CMD_RD_SNOOP;
    return c;
  endfunction

  function automatic logic [11:0] enable_cmd(input logic [1:0] origin, input logic wr);
    logic [11:0] c;
    c = '0;
    c[3*int'(origin) +: 3] = wr ? CMD_EN_WR : CMD_EN_RD;
    return c;
  endfunction

  // Pops are blocked during reset so no entry is lost while rst is high.
  assign pop        = (state_q == IDLE) && !bus.broad_fifo_empty_i && !rst;
  assign head_valid = (bus.broad_type_i == TYPE_WR) || (bus.broad_type_i == TYPE_RD);
  assign head_pend  = bus.cpu_present_i & ~(4'b0001 << bus.broad_cpu_id_i);
  assign wd_inc     = (wd_q == 8'hFF) ? wd_q : wd_q + 8'd1;

  always_comb begin
    state_n = state_q;
    pend_n  = pend_q;
    cmd_n   = '0;
    wd_n    = wd_q;
    err_n   = 1'b0;
    tmo_n   = 1'b0;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          if (head_valid) begin
            latch   = 1'b1;
            state_n = SNOOP;
            pend_n  = head_pend;
            wd_n    = '0;
            cmd_n   = snoop_cmds(head_pend, bus.broad_type_i == TYPE_WR);
          end else begin
            err_n = 1'b1;
          end
        end
      end
      SNOOP: begin
        wd_n = wd_inc;
        if (wd_q >= WD_LIMIT) begin
          state_n = IDLE;
          pend_n  = '0;
          tmo_n   = 1'b1;
        end else begin
          // Acks on non-pending ports fall out of the mask naturally.
          pend_n = pend_q & ~bus.cbus_ack_array_i;
          if (pend_n == 4'd0) begin
            state_n = ENABLE;
            cmd_n   = enable_cmd(origin_q, is_wr_q);
          end else begin
            cmd_n = snoop_cmds(pend_n, is_wr_q);
          end
        end
      end
      ENABLE: begin
        wd_n = wd_inc;
        if (wd_q >= WD_LIMIT) begin
          state_n = IDLE;
          tmo_n   = 1'b1;
        end else if (bus.cbus_ack_array_i[origin_q]) begin
          state_n = IDLE;
        end else begin
          cmd_n = enable_cmd(origin_q, is_wr_q);
        end
      end
      default: begin
        state_n = IDLE;
        pend_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      cmd_q    <= '0;
      wd_q     <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      is_wr_q  <= 1'b0;
      origin_q <= '0;
      addr_q   <= '0;
      id_q     <= '0;
    end else begin
      state_q <= state_n;
      pend_q  <= pend_n;
      cmd_q   <= cmd_n;
      wd_q    <= wd_n;
      err_q   <= err_n;
      tmo_q   <= tmo_n;
      if (latch) begin
        is_wr_q  <= (bus.broad_type_i == TYPE_WR);
        origin_q <= bus.broad_cpu_id_i;
        addr_q   <= bus.broad_addr_i;
        id_q     <= bus.broad_id_i;
      end
    end
  end

  assign bus.broad_fifo_rd_o  = pop;
  assign bus.cbus_cmd_array_o = cmd_q;
  assign bus.cbus_addr_o      = addr_q;
  assign bus.active_id_o      = id_q;
  assign bus.busy_o           = (state_q != IDLE);
  assign bus.err_o            = err_q;
  assign bus.timeout_o        = tmo_q;
  assign state_dbg            = state_q;

endmodule
